dm_access_unit: RTL and testbench

Memory-stage load/store unit that sits directly upstream of the word-addressed data memory. It converts byte-addressed pipeline requests (byte/half/word, signed/unsigned) into DM word accesses. It performs read-modify-write for sub-word stores, extracts and extends sub-word load data, and stalls the pipeline while a multi-cycle access is in progress.

---
 rtl/dm_access_if.sv | 39 +++
 rtl/dm_access_unit.sv | 172 +++++++++++++++++
 tb/tb_dm_access_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_if.sv
// Bundle of the pipeline-side request/response signals and the data-memory
// port used by dm_access_unit. The slave modport is the access unit; the
// master modport is the surrounding pipeline plus data memory.
interface dm_access_if #(
   parameter int ADDR_W = 14
);
   // pipeline request
   logic              req_valid;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   // pipeline response
   logic              stall;
   logic              rdata_valid;
   logic [31:0]       rdata;
   logic              misaligned;
   // data-memory port
   logic              DM_read;
   logic              DM_write;
   logic [ADDR_W-1:0] DM_addr;
   logic [31:0]       DM_in;
   logic [31:0]       DM_out;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  DM_out,
      output stall, rdata_valid, rdata, misaligned,
      output DM_read, DM_write, DM_addr, DM_in
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output DM_out,
      input  stall, rdata_valid, rdata, misaligned,
      input  DM_read, DM_write, DM_addr, DM_in
   );
endinterface

// File: rtl/dm_access_unit.sv
// Memory-stage load/store unit in front of a word-addressed data memory.
// Byte-addressed byte/half/word requests become word accesses; sub-word
// stores use read-modify-write, loads extract and extend the addressed lane.
// All outputs are combinational from state and the live request, and are
// forced to zero while rst is high so the reset takes effect immediately.
module dm_access_unit #(
   parameter int ADDR_W = 14
) (
   input  logic       clk,
   input  logic       rst,
   dm_access_if.slave bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LD_WAIT = 2'd1;
   localparam logic [1:0] S_ST_RMW  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [1:0]        size_q,  size_d;
   logic [1:0]        lane_q,  lane_d;
   logic              uns_q,   uns_d;
   logic [31:0]       wdata_q, wdata_d;

   // request decode
   logic        req_word, req_half, req_mis, req_ok;
   logic        launch_ld, launch_rmw, word_st;
   logic [ADDR_W-1:0] req_waddr;

   // load extraction and store merge
   logic [31:0] ld_shift, ld_ext;
   logic [31:0] st_rep, st_merged;
   logic [3:0]  st_be;

   // pre-mask outputs
   logic              stall_c, rdata_valid_c, misaligned_c, read_c, write_c;
   logic [31:0]       rdata_c, din_c;
   logic [ADDR_W-1:0] addr_c;

   // address bits above the DM word index are deliberately ignored
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

   // Classify the live request: size 11 behaves as word.
   always_comb begin
      req_word   = bus.req_size[1];
      req_half   = (bus.req_size == 2'b01);
      req_mis    = bus.req_valid &&
                   ((req_half && bus.req_addr[0]) ||
                    (req_word && (bus.req_addr[1:0] != 2'b00)));
      req_ok     = bus.req_valid && !req_mis;
      launch_ld  = req_ok && !bus.req_we;
      launch_rmw = req_ok && bus.req_we && !req_word;
      word_st    = req_ok && bus.req_we && req_word;
      req_waddr  = bus.req_addr[ADDR_W+1:2];
   end

   // Shift the addressed lane to bit 0, then zero- or sign-extend it.
   always_comb begin
      ld_shift = bus.DM_out >> {lane_q, 3'b000};
      case (size_q)
         2'b00:   ld_ext = uns_q ? {24'd0, ld_shift[7:0]}
                                 : {{24{ld_shift[7]}}, ld_shift[7:0]};
         2'b01:   ld_ext = uns_q ? {16'd0, ld_shift[15:0]}
                                 : {{16{ld_shift[15]}}, ld_shift[15:0]};
         default: ld_ext = bus.DM_out;
      endcase
      // replicate the store data into every lane; the byte enables pick one
      st_rep = (size_q == 2'b00) ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
   end

   // Per-lane merge of old word and latched store data.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign st_be[gi] = (size_q == 2'b00) ? (lane_q == 2'(gi))
                          : (size_q == 2'b01) ? (lane_q[1] == 1'(gi / 2))
                          : 1'b1;
         assign st_merged[8*gi +: 8] = st_be[gi] ? st_rep[8*gi +: 8]
                                                 : bus.DM_out[8*gi +: 8];
      end
   endgenerate

   // Next-state and output logic; outputs are zeroed while in reset.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      size_d        = size_q;
      lane_d        = lane_q;
      uns_d         = uns_q;
      wdata_d       = wdata_q;
      stall_c       = 1'b0;
      rdata_valid_c = 1'b0;
      rdata_c       = 32'd0;
      misaligned_c  = 1'b0;
      read_c        = 1'b0;
      write_c       = 1'b0;
      addr_c        = '0;
      din_c         = 32'd0;
      case (state_q)
         S_IDLE: begin
            addr_c       = req_waddr;
            misaligned_c = req_mis;
            if (word_st) begin
               write_c = 1'b1;
               din_c   = bus.req_wdata;
            end
            if (launch_ld || launch_rmw) begin
               read_c  = 1'b1;
               stall_c = 1'b1;
               addr_d  = req_waddr;
               size_d  = bus.req_size;
               lane_d  = bus.req_addr[1:0];
               uns_d   = bus.req_unsigned;
               wdata_d = bus.req_wdata;
               state_d = launch_ld ? S_LD_WAIT : S_ST_RMW;
            end
         end
         S_LD_WAIT: begin
            addr_c        = addr_q;
            rdata_valid_c = 1'b1;
            rdata_c       = ld_ext;
            state_d       = S_IDLE;
         end
         S_ST_RMW: begin
            addr_c  = addr_q;
            write_c = 1'b1;
            din_c   = st_merged;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (rst) begin
         stall_c       = 1'b0;
         rdata_valid_c = 1'b0;
         rdata_c       = 32'd0;
         misaligned_c  = 1'b0;
         read_c        = 1'b0;
         write_c       = 1'b0;
         addr_c        = '0;
         din_c         = 32'd0;
      end
   end

   assign bus.stall       = stall_c;
   assign bus.rdata_valid = rdata_valid_c;
   assign bus.rdata       = rdata_c;
   assign bus.misaligned  = misaligned_c;
   assign bus.DM_read     = read_c;
   assign bus.DM_write    = write_c;
   assign bus.DM_addr     = addr_c;
   assign bus.DM_in       = din_c;

   // State and latched request fields; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         size_q  <= 2'b00;
         lane_q  <= 2'b00;
         uns_q   <= 1'b0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         lane_q  <= lane_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: a behavioural word memory with a
// registered read port sits behind the DM port, requests come from tables
// of hand-computed vectors, plus hand-written reset sequences.
module tb_dm_access_unit;

   localparam int AW = 14;

   logic clk;
   logic rst;

   dm_access_if #(.ADDR_W(AW)) bus ();

   dm_access_unit #(.ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // data memory model: synchronous write, registered read
   logic [31:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bus.DM_write) mem[bus.DM_addr] <= bus.DM_in;
      if (bus.DM_read)  bus.DM_out <= mem[bus.DM_addr];
   end

   // strobes must never overlap
   int both_strobe_cnt = 0;
   always @(negedge clk) begin
      if (bus.DM_read && bus.DM_write) both_strobe_cnt++;
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;   // rdata for loads, DM_in for stores
      logic        mis;
   } vec_t;

   vec_t tab  [22];
   vec_t wrap [8];

   int errors = 0;
   int checks = 0;

   task automatic chk(input int idx, input string nm,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL vec %0d %s: got %h expected %h", idx, nm, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic        exp_stall, exp_wr;
      logic [31:0] wa;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = v.we;
      bus.req_size     = v.size;
      bus.req_unsigned = v.uns;
      bus.req_addr     = v.addr;
      bus.req_wdata    = v.wdata;
      #1;
      exp_stall = !v.mis && (!v.we || (v.size[1] == 1'b0));
      exp_wr    = !v.mis && v.we && v.size[1];
      wa        = {18'd0, v.addr[15:2]};
      chk(idx, "misaligned", {31'd0, bus.misaligned}, {31'd0, v.mis});
      chk(idx, "stall", {31'd0, bus.stall}, {31'd0, exp_stall});
      chk(idx, "DM_read", {31'd0, bus.DM_read}, {31'd0, exp_stall});
      chk(idx, "DM_write", {31'd0, bus.DM_write}, {31'd0, exp_wr});
      chk(idx, "rdata_valid", {31'd0, bus.rdata_valid}, 32'd0);
      if (!v.mis) chk(idx, "DM_addr", {18'd0, bus.DM_addr}, wa);
      if (exp_wr) chk(idx, "DM_in", bus.DM_in, v.exp);
      if (exp_stall) begin
         @(negedge clk);
         #1;
         chk(idx, "stall2", {31'd0, bus.stall}, 32'd0);
         chk(idx, "DM_read2", {31'd0, bus.DM_read}, 32'd0);
         chk(idx, "DM_addr2", {18'd0, bus.DM_addr}, wa);
         if (!v.we) begin
            chk(idx, "rdata_valid2", {31'd0, bus.rdata_valid}, 32'd1);
            chk(idx, "rdata", bus.rdata, v.exp);
            chk(idx, "DM_write2", {31'd0, bus.DM_write}, 32'd0);
         end else begin
            chk(idx, "DM_write2", {31'd0, bus.DM_write}, 32'd1);
            chk(idx, "DM_in2", bus.DM_in, v.exp);
            chk(idx, "rdata_valid2", {31'd0, bus.rdata_valid}, 32'd0);
         end
      end
      $display("vec %0d: we=%0d size=%0d uns=%0d addr=%h wdata=%h exp=%h mis=%0d",
               idx, v.we, v.size, v.uns, v.addr, v.wdata, v.exp, v.mis);
   endtask

   task automatic chk_all_zero(input int idx);
      chk(idx, "stall", {31'd0, bus.stall}, 32'd0);
      chk(idx, "rdata_valid", {31'd0, bus.rdata_valid}, 32'd0);
      chk(idx, "rdata", bus.rdata, 32'd0);
      chk(idx, "misaligned", {31'd0, bus.misaligned}, 32'd0);
      chk(idx, "DM_read", {31'd0, bus.DM_read}, 32'd0);
      chk(idx, "DM_write", {31'd0, bus.DM_write}, 32'd0);
      chk(idx, "DM_addr", {18'd0, bus.DM_addr}, 32'd0);
      chk(idx, "DM_in", bus.DM_in, 32'd0);
   endtask

   initial begin
      //            we    size   uns   addr          wdata          exp            mis
      tab[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,       32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      tab[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
      tab[2]  = '{1'b1, 2'b10, 1'b0, 32'h10,       32'h11223344, 32'h11223344, 1'b0};
      tab[3]  = '{1'b1, 2'b00, 1'b0, 32'h11,       32'h000000A5, 32'h1122A544, 1'b0};
      tab[4]  = '{1'b0, 2'b10, 1'b0, 32'h10,       32'h0,        32'h1122A544, 1'b0};
      tab[5]  = '{1'b1, 2'b10, 1'b0, 32'h20,       32'h80FF7F01, 32'h80FF7F01, 1'b0};
      tab[6]  = '{1'b0, 2'b00, 1'b0, 32'h22,       32'h0,        32'hFFFFFFFF, 1'b0};
      tab[7]  = '{1'b0, 2'b00, 1'b1, 32'h22,       32'h0,        32'h000000FF, 1'b0};
      tab[8]  = '{1'b0, 2'b01, 1'b0, 32'h22,       32'h0,        32'hFFFF80FF, 1'b0};
      tab[9]  = '{1'b0, 2'b00, 1'b1, 32'h20,       32'h0,        32'h00000001, 1'b0};
      tab[10] = '{1'b0, 2'b01, 1'b0, 32'h13,       32'h0,        32'h0,        1'b1};
      tab[11] = '{1'b1, 2'b10, 1'b0, 32'h06,       32'h55555555, 32'h0,        1'b1};
      tab[12] = '{1'b1, 2'b01, 1'b0, 32'h22,       32'h00001234, 32'h12347F01, 1'b0};
      tab[13] = '{1'b0, 2'b01, 1'b0, 32'h20,       32'h0,        32'h00007F01, 1'b0};
      tab[14] = '{1'b0, 2'b00, 1'b0, 32'h21,       32'h0,        32'h0000007F, 1'b0};
      tab[15] = '{1'b0, 2'b10, 1'b0, 32'h20,       32'h0,        32'h12347F01, 1'b0};
      tab[16] = '{1'b1, 2'b00, 1'b0, 32'h23,       32'hFFFFFFCD, 32'hCD347F01, 1'b0};
      tab[17] = '{1'b0, 2'b01, 1'b1, 32'h22,       32'h0,        32'h0000CD34, 1'b0};
      tab[18] = '{1'b0, 2'b01, 1'b0, 32'h22,       32'h0,        32'hFFFFCD34, 1'b0};
      tab[19] = '{1'b0, 2'b11, 1'b0, 32'h20,       32'h0,        32'hCD347F01, 1'b0};
      tab[20] = '{1'b1, 2'b01, 1'b0, 32'h21,       32'h0000AAAA, 32'h0,        1'b1};
      tab[21] = '{1'b0, 2'b10, 1'b0, 32'h22,       32'h0,        32'h0,        1'b1};

      // alternating store/load stream around the top word index and wrap to 0
      wrap[0] = '{1'b1, 2'b10, 1'b0, 32'h0000FFFC, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
      wrap[1] = '{1'b0, 2'b00, 1'b1, 32'h0001FFFF, 32'h0,        32'h000000CA, 1'b0};
      wrap[2] = '{1'b1, 2'b10, 1'b0, 32'h00010000, 32'h01234567, 32'h01234567, 1'b0};
      wrap[3] = '{1'b0, 2'b10, 1'b0, 32'h00000000, 32'h0,        32'h01234567, 1'b0};
      wrap[4] = '{1'b1, 2'b01, 1'b0, 32'h0000FFFE, 32'h0000BEEF, 32'hBEEFF00D, 1'b0};
      wrap[5] = '{1'b0, 2'b01, 1'b0, 32'h0003FFFE, 32'h0,        32'hFFFFBEEF, 1'b0};
      wrap[6] = '{1'b1, 2'b00, 1'b0, 32'h00010003, 32'h00000089, 32'h89234567, 1'b0};
      wrap[7] = '{1'b0, 2'b10, 1'b0, 32'h00020000, 32'h0,        32'h89234567, 1'b0};

      // reset state, with a live load presented to show the masking
      rst              = 1'b1;
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b10;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h10;
      bus.req_wdata    = 32'h0;
      #2;
      chk_all_zero(100);
      @(negedge clk);
      rst           = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      chk(101, "idle DM_read", {31'd0, bus.DM_read}, 32'd0);
      chk(101, "idle DM_write", {31'd0, bus.DM_write}, 32'd0);
      chk(101, "idle stall", {31'd0, bus.stall}, 32'd0);
      $display("vec 101: reset released, idle with no request");

      for (int i = 0; i < 22; i++) run_vec(i, tab[i]);
      for (int i = 0; i < 8; i++)  run_vec(200 + i, wrap[i]);

      // sub-word store aborted by reset during the RMW write cycle
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b1;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h10;
      bus.req_wdata    = 32'h00000077;
      #1;
      chk(300, "rmw launch stall", {31'd0, bus.stall}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_all_zero(300);
      @(negedge clk);
      rst           = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      chk(301, "post-reset DM_write", {31'd0, bus.DM_write}, 32'd0);
      chk(301, "post-reset rdata_valid", {31'd0, bus.rdata_valid}, 32'd0);
      $display("vec 300: byte store at 00000010 aborted by reset");
      // word must still hold its pre-abort value, and IDLE accepts a load
      run_vec(302, '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122A544, 1'b0});

      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      chk(400, "strobe overlap count", both_strobe_cnt, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
